// File: rtl/blob_xr_extract_if.sv
// Pixel-stream / result bundle between the thresholding front end and blob_xr_extract.
// master drives the pixel stream and frame pulses; slave returns the per-frame target result.
interface blob_xr_extract_if;
   logic       frame_start;
   logic       frame_end;
   logic       pix_valid;
   logic [8:0] hcount;
   logic [7:0] vcount;
   logic       mask;
   logic [8:0] pre_x;
   logic [6:0] pre_rad;
   logic       result_valid;
   logic       busy;

   modport master (
      output frame_start, frame_end, pix_valid, hcount, vcount, mask,
      input  pre_x, pre_rad, result_valid, busy
   );

   modport slave (
      input  frame_start, frame_end, pix_valid, hcount, vcount, mask,
      output pre_x, pre_rad, result_valid, busy
   );
endinterface

// File: rtl/blob_xr_extract.sv
// Per-frame bounding-box extractor: centre x and radius of the colour-matched blob, 9'h1FF if none.
// Optional run-length noise filter enabled by defining BLOB_RUN_FILTER_EN.
module blob_xr_extract #(
   parameter int H_ACTIVE   = 320,
   parameter int V_ACTIVE   = 240,
   parameter int MIN_PIXELS = 64,
   parameter int CNT_W      = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   blob_xr_extract_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, CALC, OUT} state_t;

   localparam logic [8:0]       H_LIM = 9'(H_ACTIVE);
   localparam logic [7:0]       V_LIM = 8'(V_ACTIVE);
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PIXELS);

   state_t           state, state_nxt;
   logic             start_pend;
   logic [8:0]       min_x, max_x, n_min_x, n_max_x, b_min_x, b_max_x;
   logic [7:0]       min_y, max_y, n_min_y, n_max_y, b_min_y, b_max_y;
   logic [CNT_W-1:0] cnt, n_cnt, b_cnt;
   logic             run_ok, qual, fs_take, clr, acc_en;

   // ---------------- run-length filter ----------------
`ifdef BLOB_RUN_FILTER_EN
   logic       run_mask;
   logic [7:0] run_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_mask <= 1'b0;
         run_v    <= '0;
      end else if (bus.frame_start || bus.pix_valid) begin
         run_mask <= bus.pix_valid & bus.mask;
         run_v    <= bus.vcount;
      end
   end

   // The frame_start pixel always opens a new run, so it never qualifies.
   assign run_ok = run_mask & (run_v == bus.vcount) & ~bus.frame_start;
`else
   assign run_ok = 1'b1;
`endif

   assign qual = bus.pix_valid & bus.mask & run_ok &
                 (bus.hcount < H_LIM) & (bus.vcount < V_LIM);

   // A frame_start colliding with frame_end in ACCUM must not clobber the finishing frame;
   // it is deferred and the clear happens on the CALC cycle, once the result is captured.
   assign fs_take = bus.frame_start & ~((state == ACCUM) & bus.frame_end);
   assign clr     = fs_take | ((state == CALC) & start_pend);
   assign acc_en  = qual & (((state == ACCUM) & ~bus.frame_end) | fs_take);

   always_comb begin
      b_min_x = clr ? 9'h1FF : min_x;
      b_max_x = clr ? 9'h000 : max_x;
      b_min_y = clr ? 8'hFF  : min_y;
      b_max_y = clr ? 8'h00  : max_y;
      b_cnt   = clr ? '0     : cnt;
      n_min_x = b_min_x;
      n_max_x = b_max_x;
      n_min_y = b_min_y;
      n_max_y = b_max_y;
      n_cnt   = b_cnt;
      if (acc_en) begin
         if (bus.hcount < b_min_x) n_min_x = bus.hcount;
         if (bus.hcount > b_max_x) n_max_x = bus.hcount;
         if (bus.vcount < b_min_y) n_min_y = bus.vcount;
         if (bus.vcount > b_max_y) n_max_y = bus.vcount;
         if (!(&b_cnt))            n_cnt   = b_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_x <= 9'h1FF;
         max_x <= '0;
         min_y <= 8'hFF;
         max_y <= '0;
         cnt   <= '0;
      end else begin
         min_x <= n_min_x;
         max_x <= n_max_x;
         min_y <= n_min_y;
         max_y <= n_max_y;
         cnt   <= n_cnt;
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         start_pend <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == OUT)
            start_pend <= 1'b0;
         else if (((state == ACCUM) & bus.frame_end & bus.frame_start) |
                  ((state == CALC) & bus.frame_start))
            start_pend <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.frame_start) state_nxt = ACCUM;
         ACCUM:   if (bus.frame_end)   state_nxt = CALC;
         CALC:    state_nxt = OUT;
         OUT:     state_nxt = (start_pend | bus.frame_start) ? ACCUM : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.result_valid = (state == OUT);
      bus.busy         = (state == ACCUM) | (state == CALC);
   end

   // ---------------- CALC arithmetic ----------------
   logic [8:0] x_c;
   logic [9:0] w, mx, r_half;
   logic [8:0] h;
   logic [6:0] r_c;
   logic       tgt_ok;

   always_comb begin
      x_c    = 9'(({1'b0, min_x} + {1'b0, max_x}) >> 1);
      w      = {1'b0, max_x} - {1'b0, min_x} + 10'd1;
      h      = {1'b0, max_y} - {1'b0, min_y} + 9'd1;
      mx     = (w > {1'b0, h}) ? w : {1'b0, h};
      r_half = 10'(({1'b0, mx} + 11'd1) >> 1);
      r_c    = (|r_half[9:7]) ? 7'd127 : r_half[6:0];
      tgt_ok = (cnt >= MIN_C);
   end

   // Result is captured leaving CALC so it is already visible while result_valid is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pre_x   <= 9'h1FF;
         bus.pre_rad <= '0;
      end else if (state == CALC) begin
         bus.pre_x   <= tgt_ok ? x_c : 9'h1FF;
         bus.pre_rad <= tgt_ok ? r_c : 7'd0;
      end
   end

endmodule

// File: tb/tb_blob_xr_extract.sv
// Directed bench for blob_xr_extract (default build, run filter disabled).
module tb_blob_xr_extract;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails  = 0;

   blob_xr_extract_if bif ();

   blob_xr_extract dut (.clk(clk), .rst_n(rst_n), .bus(bif));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic cyc(input logic fs, input logic fe, input logic pv,
                      input logic [8:0] h, input logic [7:0] v, input logic m);
      bif.frame_start = fs;
      bif.frame_end   = fe;
      bif.pix_valid   = pv;
      bif.hcount      = h;
      bif.vcount      = v;
      bif.mask        = m;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 9'd0, 8'd0, 0);
   endtask

   task automatic square();
      for (int y = 50; y < 90; y++)
         for (int x = 100; x < 140; x++)
            cyc(0, 0, 1, 9'(x), 8'(y), 1);
   endtask

   task automatic row(input int n);
      for (int x = 0; x < n; x++)
         cyc(x == 0, 0, 1, 9'(x), 8'd10, 1);
   endtask

   task automatic finish_frame(input string tag, input logic [8:0] ex, input logic [6:0] er);
      cyc(0, 1, 0, 9'd0, 8'd0, 0);
      chk({tag, "_rv_lat1"}, bif.result_valid, 1'b0);
      idle();
      chk({tag, "_rv"},   bif.result_valid, 1'b1);
      chk({tag, "_x"},    bif.pre_x, ex);
      chk({tag, "_rad"},  bif.pre_rad, er);
      idle();
      chk({tag, "_rv_off"}, bif.result_valid, 1'b0);
      chk({tag, "_hold"},   bif.pre_x, ex);
   endtask

   initial begin
      bif.frame_start = 0; bif.frame_end = 0; bif.pix_valid = 0;
      bif.hcount = 0; bif.vcount = 0; bif.mask = 0;
      #12;
      chk("rst_x",    bif.pre_x, 9'h1FF);
      chk("rst_rad",  bif.pre_rad, 7'd0);
      chk("rst_rv",   bif.result_valid, 1'b0);
      chk("rst_busy", bif.busy, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();

      // 40x40 square blob
      cyc(1, 0, 0, 9'd0, 8'd0, 0);
      chk("sq_busy", bif.busy, 1'b1);
      square();
      finish_frame("sq", 9'd119, 7'd20);
      chk("sq_idle_busy", bif.busy, 1'b0);

      // 63 pixels: below threshold
      row(63);
      finish_frame("p63", 9'h1FF, 7'd0);

      // 64 pixels, first one on the frame_start cycle
      row(64);
      finish_frame("p64", 9'd31, 7'd32);

      // only out-of-area pixels
      cyc(1, 0, 0, 9'd0, 8'd0, 0);
      for (int i = 0; i < 100; i++) cyc(0, 0, 1, 9'd330, 8'(i), 1);
      for (int i = 0; i < 100; i++) cyc(0, 0, 1, 9'(i), 8'd245, 1);
      finish_frame("oor", 9'h1FF, 7'd0);

      // frame_end while IDLE is ignored
      cyc(0, 1, 0, 9'd0, 8'd0, 0);
      chk("idle_fe_busy", bif.busy, 1'b0);
      idle();
      chk("idle_fe_rv1", bif.result_valid, 1'b0);
      idle();
      chk("idle_fe_rv2", bif.result_valid, 1'b0);

      // reset mid-frame after a valid result
      cyc(1, 0, 0, 9'd0, 8'd0, 0);
      square();
      finish_frame("pre_rst", 9'd119, 7'd20);
      cyc(1, 0, 0, 9'd0, 8'd0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 9'(200 + i), 8'd20, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_x",    bif.pre_x, 9'h1FF);
      chk("mid_rst_rad",  bif.pre_rad, 7'd0);
      chk("mid_rst_busy", bif.busy, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();
      row(64);
      finish_frame("post_rst", 9'd31, 7'd32);

      // frame_start and frame_end together: old frame out, new frame accumulated
      cyc(1, 0, 0, 9'd0, 8'd0, 0);
      square();
      cyc(1, 1, 1, 9'd300, 8'd200, 1);
      chk("sim_calc_busy", bif.busy, 1'b1);
      chk("sim_calc_rv",   bif.result_valid, 1'b0);
      idle();
      chk("sim_rv",  bif.result_valid, 1'b1);
      chk("sim_x",   bif.pre_x, 9'd119);
      chk("sim_rad", bif.pre_rad, 7'd20);
      idle();
      chk("sim_accum_busy", bif.busy, 1'b1);
      chk("sim_accum_rv",   bif.result_valid, 1'b0);
      for (int x = 0; x < 64; x++) cyc(0, 0, 1, 9'(x), 8'd10, 1);
      finish_frame("b2b", 9'd31, 7'd32);

      // full-screen mask, radius saturates
      cyc(1, 0, 0, 9'd0, 8'd0, 0);
      for (int y = 0; y < 240; y++)
         for (int x = 0; x < 320; x++)
            cyc(0, 0, 1, 9'(x), 8'(y), 1);
      finish_frame("full", 9'd159, 7'd127);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
